// File: rtl/bu_buf_mgr_pkg.sv
// Shared definitions for the NOU buffer unit: widths, slot status codes and
// the buffer manager FSM state type.
package bu_buf_mgr_pkg;

    localparam int unsigned NOU_BUF_ADDR_WIDTH        = 16;
    localparam int unsigned NOU_BUF_SZ_WIDTH          = 16;
    localparam int unsigned NOU_BUF_SLOT_STATUS_WIDTH = 2;

    // Any status other than FREE counts as not-free; only these two are ever written.
    localparam logic [NOU_BUF_SLOT_STATUS_WIDTH-1:0] NOU_BUF_SLOT_FREE  = 2'd0;
    localparam logic [NOU_BUF_SLOT_STATUS_WIDTH-1:0] NOU_BUF_SLOT_ALLOC = 2'd1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResp
    } bu_mgr_state_e;

endpackage

// File: rtl/bu_buf_slot.sv
// One buffer-slot register: status is writable, address and size are loaded
// from the reset-value inputs while rstn is low and held afterwards.
module bu_buf_slot
    import bu_buf_mgr_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NOU_BUF_ADDR_WIDTH-1:0]        rst_addr,
    input  logic [NOU_BUF_SZ_WIDTH-1:0]          rst_size,
    input  logic                                 wr_en,
    input  logic [NOU_BUF_SLOT_STATUS_WIDTH-1:0] wr_status,
    output logic [NOU_BUF_SLOT_STATUS_WIDTH-1:0] status,
    output logic [NOU_BUF_ADDR_WIDTH-1:0]        addr,
    output logic [NOU_BUF_SZ_WIDTH-1:0]          size
);

    logic [NOU_BUF_SLOT_STATUS_WIDTH-1:0] status_q;
    logic [NOU_BUF_ADDR_WIDTH-1:0]        addr_q;
    logic [NOU_BUF_SZ_WIDTH-1:0]          size_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            status_q <= NOU_BUF_SLOT_FREE;
            addr_q   <= rst_addr;
            size_q   <= rst_size;
        end else if (wr_en) begin
            status_q <= wr_status;
        end
    end

    assign status = status_q;
    assign addr   = addr_q;
    assign size   = size_q;

endmodule

// File: rtl/bu_buf_mgr.sv
// Buffer-slot manager: round-robin arbitration of allocation requests, linear
// first-fit scan over the slot bank, and a single free port.
module bu_buf_mgr
    import bu_buf_mgr_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned NUM_REQ   = 4
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NOU_BUF_ADDR_WIDTH-1:0]        cfg_base_addr,
    input  logic [NOU_BUF_SZ_WIDTH-1:0]          cfg_slot_size,
    input  logic [NUM_REQ-1:0]                   alloc_req,
    input  logic [NUM_REQ*NOU_BUF_SZ_WIDTH-1:0]  alloc_size,
    output logic [NUM_REQ-1:0]                   alloc_gnt,
    output logic                                 alloc_ok,
    output logic [$clog2(NUM_SLOTS)-1:0]         alloc_slot,
    output logic [NOU_BUF_ADDR_WIDTH-1:0]        alloc_addr,
    input  logic                                 free_vld,
    input  logic [$clog2(NUM_SLOTS)-1:0]         free_slot,
    output logic                                 free_err,
    output logic [$clog2(NUM_SLOTS):0]           free_cnt
);

    localparam int unsigned AW  = NOU_BUF_ADDR_WIDTH;
    localparam int unsigned SZW = NOU_BUF_SZ_WIDTH;
    localparam int unsigned STW = NOU_BUF_SLOT_STATUS_WIDTH;
    localparam int unsigned SW  = $clog2(NUM_SLOTS);
    localparam int unsigned RW  = $clog2(NUM_REQ);
    localparam int unsigned CW  = SW + 1;

    bu_mgr_state_e        state_q, state_d;
    logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]        win_idx_q, win_idx_d;
    logic [SZW-1:0]       win_size_q, win_size_d;
    logic [SW-1:0]        scan_idx_q, scan_idx_d;
    logic [NUM_REQ-1:0]   alloc_gnt_q, alloc_gnt_d;
    logic                 alloc_ok_q, alloc_ok_d;
    logic [SW-1:0]        alloc_slot_q, alloc_slot_d;
    logic [AW-1:0]        alloc_addr_q, alloc_addr_d;
    logic                 free_err_q;
    logic [CW-1:0]        free_cnt_q;

    logic [STW-1:0]       slot_status [NUM_SLOTS];
    logic [AW-1:0]        slot_addr   [NUM_SLOTS];
    logic [SZW-1:0]       slot_size   [NUM_SLOTS];

    logic                 arb_found;
    logic [RW-1:0]        arb_idx;
    int unsigned          cand;
    logic [RW-1:0]        cand_idx;
    logic                 scan_hit;
    logic                 alloc_wr;
    logic                 free_ok;

    // The allocation write lands at the end of RESP, so a same-cycle free still
    // sees the slot as FREE and is rejected.
    assign alloc_wr = (state_q == StResp) && alloc_ok_q;
    assign free_ok  = free_vld && (slot_status[free_slot] == NOU_BUF_SLOT_ALLOC);
    assign scan_hit = (slot_status[scan_idx_q] == NOU_BUF_SLOT_FREE) &&
                      (slot_size[scan_idx_q] >= win_size_q);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [AW-1:0]  rst_addr;
        logic           alloc_sel;
        logic           free_sel;
        logic           wr_en;
        logic [STW-1:0] wr_status;

        assign rst_addr  = cfg_base_addr + AW'(i) * AW'(cfg_slot_size);
        assign alloc_sel = alloc_wr && (alloc_slot_q == SW'(i));
        assign free_sel  = free_ok && (free_slot == SW'(i));
        assign wr_en     = alloc_sel || free_sel;
        assign wr_status = alloc_sel ? NOU_BUF_SLOT_ALLOC : NOU_BUF_SLOT_FREE;

        bu_buf_slot u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .rst_addr  (rst_addr),
            .rst_size  (cfg_slot_size),
            .wr_en     (wr_en),
            .wr_status (wr_status),
            .status    (slot_status[i]),
            .addr      (slot_addr[i]),
            .size      (slot_size[i])
        );
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = RW'(cand);
            if (!arb_found && alloc_req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_idx_d    = win_idx_q;
        win_size_d   = win_size_q;
        scan_idx_d   = scan_idx_q;
        alloc_gnt_d  = '0;
        alloc_ok_d   = 1'b0;
        alloc_slot_d = alloc_slot_q;
        alloc_addr_d = alloc_addr_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    win_idx_d  = arb_idx;
                    win_size_d = alloc_size[32'(arb_idx) * SZW +: SZW];
                    scan_idx_d = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (scan_hit) begin
                    state_d                = StResp;
                    alloc_gnt_d[win_idx_q] = 1'b1;
                    alloc_ok_d             = 1'b1;
                    alloc_slot_d           = scan_idx_q;
                    alloc_addr_d           = slot_addr[scan_idx_q];
                end else if (scan_idx_q == SW'(NUM_SLOTS - 1)) begin
                    state_d                = StResp;
                    alloc_gnt_d[win_idx_q] = 1'b1;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            StResp: begin
                rr_ptr_d = (win_idx_q == RW'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            win_idx_q    <= '0;
            win_size_q   <= '0;
            scan_idx_q   <= '0;
            alloc_gnt_q  <= '0;
            alloc_ok_q   <= 1'b0;
            alloc_slot_q <= '0;
            alloc_addr_q <= '0;
            free_err_q   <= 1'b0;
            free_cnt_q   <= CW'(NUM_SLOTS);
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_idx_q    <= win_idx_d;
            win_size_q   <= win_size_d;
            scan_idx_q   <= scan_idx_d;
            alloc_gnt_q  <= alloc_gnt_d;
            alloc_ok_q   <= alloc_ok_d;
            alloc_slot_q <= alloc_slot_d;
            alloc_addr_q <= alloc_addr_d;
            free_err_q   <= free_vld && !free_ok;
            free_cnt_q   <= free_cnt_q + CW'(free_ok) - CW'(alloc_wr);
        end
    end

    assign alloc_gnt  = alloc_gnt_q;
    assign alloc_ok   = alloc_ok_q;
    assign alloc_slot = alloc_slot_q;
    assign alloc_addr = alloc_addr_q;
    assign free_err   = free_err_q;
    assign free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_bu_buf_mgr.sv
// Scoreboard bench for bu_buf_mgr: stimulus pushes expected grants/frees from a
// pool model, a monitor pops and compares whenever the DUT responds.
module tb_bu_buf_mgr;
    import bu_buf_mgr_pkg::*;

    localparam int NS  = 8;
    localparam int NR  = 4;
    localparam int AW  = NOU_BUF_ADDR_WIDTH;
    localparam int SZW = NOU_BUF_SZ_WIDTH;
    localparam int SW  = $clog2(NS);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [AW-1:0]     cfg_base_addr = '0;
    logic [SZW-1:0]    cfg_slot_size = '0;
    logic [NR-1:0]     alloc_req = '0;
    logic [NR*SZW-1:0] alloc_size = '0;
    logic [NR-1:0]     alloc_gnt;
    logic              alloc_ok;
    logic [SW-1:0]     alloc_slot;
    logic [AW-1:0]     alloc_addr;
    logic              free_vld = 1'b0;
    logic [SW-1:0]     free_slot = '0;
    logic              free_err;
    logic [SW:0]       free_cnt;

    bu_buf_mgr #(.NUM_SLOTS(NS), .NUM_REQ(NR)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_base_addr (cfg_base_addr),
        .cfg_slot_size (cfg_slot_size),
        .alloc_req     (alloc_req),
        .alloc_size    (alloc_size),
        .alloc_gnt     (alloc_gnt),
        .alloc_ok      (alloc_ok),
        .alloc_slot    (alloc_slot),
        .alloc_addr    (alloc_addr),
        .free_vld      (free_vld),
        .free_slot     (free_slot),
        .free_err      (free_err),
        .free_cnt      (free_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic free_seen = 1'b0;
    always @(posedge clk) free_seen <= free_vld;

    typedef struct {
        logic [NR-1:0] gnt;
        logic          ok;
        logic [SW-1:0] slot;
        logic [AW-1:0] addr;
        int            lat;
        int            cnt;
    } alloc_exp_t;

    typedef struct {
        logic err;
        int   cnt;
    } free_exp_t;

    alloc_exp_t aq[$];
    free_exp_t  fq[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int t_ref  = 0;

    // Pool model: per-slot state plus the manager's visible registers.
    int            m_status [NS];
    logic [AW-1:0] m_addr   [NS];
    int            m_size, m_rr, m_cnt, m_slot;
    logic [AW-1:0] m_addr_last;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset(input logic [AW-1:0] base, input logic [SZW-1:0] size);
        for (int i = 0; i < NS; i++) begin
            m_status[i] = 0;
            m_addr[i]   = AW'(int'(base) + i * int'(size));
        end
        m_size = int'(size);
        m_rr = 0;
        m_cnt = NS;
        m_slot = 0;
        m_addr_last = '0;
    endfunction

    function automatic void model_alloc(input int r, input int sz, output alloc_exp_t e);
        int hit = -1;
        for (int i = 0; i < NS; i++)
            if (hit < 0 && m_status[i] == 0 && m_size >= sz) hit = i;
        e.gnt = '0;
        e.gnt[r] = 1'b1;
        if (hit >= 0) begin
            m_status[hit] = 1;
            m_cnt--;
            m_slot = hit;
            m_addr_last = m_addr[hit];
            e.ok = 1'b1;
            e.lat = hit + 2;
        end else begin
            e.ok = 1'b0;
            e.lat = NS + 1;
        end
        e.slot = SW'(m_slot);
        e.addr = m_addr_last;
        e.cnt = m_cnt;
        m_rr = (r + 1) % NR;
    endfunction

    function automatic logic [SZW-1:0] pick_size();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return SZW'(m_size);
            2:       return SZW'(m_size + 1);
            default: return SZW'($urandom_range(0, m_size));
        endcase
    endfunction

    function automatic logic [NR*SZW-1:0] sizes(input int a, input int b, input int c,
                                                input int d);
        return {SZW'(d), SZW'(c), SZW'(b), SZW'(a)};
    endfunction

    task automatic do_reset(input logic [AW-1:0] base, input logic [SZW-1:0] size);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        alloc_req = '0;
        free_vld = 1'b0;
        cfg_base_addr = base;
        cfg_slot_size = size;
        repeat (2) @(negedge clk);
        check("rst_alloc_gnt", alloc_gnt, 0);
        check("rst_alloc_ok", alloc_ok, 0);
        check("rst_alloc_slot", alloc_slot, 0);
        check("rst_alloc_addr", alloc_addr, 0);
        check("rst_free_err", free_err, 0);
        check("rst_free_cnt", free_cnt, NS);
        rstn = 1'b1;
        model_reset(base, size);
    endtask

    task automatic run_batch(input logic [NR-1:0] mask, input logic [NR*SZW-1:0] szv);
        logic [NR-1:0] pend;
        alloc_exp_t    e;
        int            w;
        @(negedge clk);
        pend = mask;
        while (pend != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && pend[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            model_alloc(w, int'(szv[w*SZW +: SZW]), e);
            aq.push_back(e);
            pend[w] = 1'b0;
        end
        t_ref = cyc;
        alloc_size = szv;
        alloc_req = mask;
        for (int n = 0; n < 200 && alloc_req != '0; n++) begin
            @(negedge clk);
            alloc_req = alloc_req & ~alloc_gnt;
        end
        if (alloc_req != '0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL batch_timeout: pending requests %b, required none", alloc_req);
            alloc_req = '0;
        end
    endtask

    task automatic do_free(input int s);
        free_exp_t f;
        @(negedge clk);
        if (m_status[s] == 1) begin
            m_status[s] = 0;
            m_cnt++;
            f.err = 1'b0;
        end else begin
            f.err = 1'b1;
        end
        f.cnt = m_cnt;
        fq.push_back(f);
        free_vld = 1'b1;
        free_slot = SW'(s);
        @(negedge clk);
        free_vld = 1'b0;
    endtask

    // Single request with a free timed into its RESP cycle.
    task automatic run_conc(input int r, input int sz, input int fslot);
        alloc_exp_t e;
        free_exp_t  f;
        int         pre;
        @(negedge clk);
        pre = m_status[fslot];
        model_alloc(r, sz, e);
        if (pre == 1) begin
            m_status[fslot] = 0;
            m_cnt++;
            f.err = 1'b0;
        end else begin
            f.err = 1'b1;
        end
        e.cnt = m_cnt;
        f.cnt = m_cnt;
        aq.push_back(e);
        fq.push_back(f);
        t_ref = cyc;
        alloc_size[r*SZW +: SZW] = SZW'(sz);
        alloc_req[r] = 1'b1;
        repeat (e.lat) @(negedge clk);
        free_vld = 1'b1;
        free_slot = SW'(fslot);
        alloc_req[r] = 1'b0;
        @(negedge clk);
        free_vld = 1'b0;
    endtask

    initial begin : monitor
        alloc_exp_t e;
        free_exp_t  f;
        logic       cnt_pend = 1'b0;
        int         cnt_exp = 0;
        forever begin
            @(negedge clk);
            if (cnt_pend) begin
                check("alloc_free_cnt", free_cnt, cnt_exp);
                cnt_pend = 1'b0;
            end
            if (free_seen) begin
                if (fq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL free_unexpected: free observed with no expectation queued");
                end else begin
                    f = fq.pop_front();
                    check("free_err", free_err, f.err);
                    check("free_cnt", free_cnt, f.cnt);
                end
            end else if (free_err) begin
                n_cmp++;
                n_fail++;
                $display("FAIL free_err_spurious: got 1, required 0 (cycle %0d)", cyc);
            end
            if (alloc_gnt != '0) begin
                if (aq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL gnt_unexpected: got %b, required none (cycle %0d)",
                             alloc_gnt, cyc);
                end else begin
                    e = aq.pop_front();
                    check("alloc_gnt", alloc_gnt, e.gnt);
                    check("alloc_ok", alloc_ok, e.ok);
                    check("alloc_slot", alloc_slot, e.slot);
                    check("alloc_addr", alloc_addr, e.addr);
                    check("alloc_latency", cyc - t_ref, e.lat);
                    cnt_pend = 1'b1;
                    cnt_exp = e.cnt;
                end
                t_ref = cyc + 1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        do_reset(16'h0100, 16'h0040);
        run_batch(4'b0100, sizes(0, 0, 'h20, 0));
        do_reset(16'h0100, 16'h0040);
        run_batch(4'b1111, sizes('h40, 'h40, 'h40, 'h40));
        run_batch(4'b0001, sizes('h20, 0, 0, 0));
        run_batch(4'b0010, sizes(0, 'h80, 0, 0));
        run_batch(4'b1111, sizes('h10, 'h10, 'h10, 'h10));
        do_free(5);
        run_batch(4'b0100, sizes(0, 0, 'h20, 0));
        do_free(6);
        do_free(6);
        run_conc(3, 'h40, 2);
        run_conc(0, 0, 2);
        // Pool is full, so this request scans every slot; reset lands mid-scan.
        @(negedge clk);
        alloc_size = '0;
        alloc_req = 4'b0001;
        repeat (4) @(negedge clk);
        do_reset(16'h3000, 16'h0100);
        run_batch(4'b0001, sizes(0, 0, 0, 0));

        for (int it = 0; it < 80; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                do_reset(AW'($urandom), SZW'($urandom_range(1, 'h300)));
            end else if (sel < 6) begin
                logic [NR-1:0]     mask;
                logic [NR*SZW-1:0] szv;
                mask = NR'($urandom_range(1, 15));
                for (int r = 0; r < NR; r++) szv[r*SZW +: SZW] = pick_size();
                run_batch(mask, szv);
            end else begin
                repeat ($urandom_range(1, 3)) do_free($urandom_range(0, NS - 1));
            end
        end

        repeat (4) @(negedge clk);
        check("alloc_queue_drained", aq.size(), 0);
        check("free_queue_drained", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
